mem_ctrl: RTL

//  Single-port byte-wide RAM arbiter feeding the IF stage and serving the MEM stage.

---
 rtl/mem_ctrl_pkg.sv | 34 +++
 rtl/mem_ctrl_byte_assembler.sv | 33 +++
 rtl/mem_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-serialising RAM arbiter.
//   state_t      : controller FSM encoding
//   MEMCNF_*     : bus-claim codes reported to the IF stage
//   DLEN_*       : data length codes (byte count minus one)
//   req_t        : access latched at acceptance (address, length, store data)
//   get_byte     : little-endian byte select from a 32-bit word
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IFETCH = 2'd1,
        DREAD  = 2'd2,
        DWRITE = 2'd3
    } state_t;

    localparam logic [1:0] MEMCNF_FREE = 2'b00;
    localparam logic [1:0] MEMCNF_WAIT = 2'b01;
    localparam logic [1:0] MEMCNF_BUSY = 2'b10;

    localparam logic [1:0] DLEN_BYTE = 2'd0;
    localparam logic [1:0] DLEN_HALF = 2'd1;
    localparam logic [1:0] DLEN_WORD = 2'd3;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] wdata;
    } req_t;

    function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [1:0] idx);
        return w[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/mem_ctrl_byte_assembler.sv
// Collects RAM bytes into a little-endian word.
//   clk, rst_n : clock, asynchronous active-low reset
//   cap        : store din into byte slot idx this edge
//   idx        : byte slot being captured
//   len        : byte count minus one; slots above len read as zero
//   din        : byte from RAM
//   word       : assembled word, with din already merged into slot idx so the
//                final byte can be registered by the parent on the same edge
module byte_assembler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cap,
    input  logic [1:0]  idx,
    input  logic [1:0]  len,
    input  logic [7:0]  din,
    output logic [31:0] word
);

    logic [3:0][7:0] bytes_q;

    // No clear between accesses: every slot 0..len is rewritten in order
    // before the word is consumed, and slots above len are masked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   bytes_q      <= '0;
        else if (cap) bytes_q[idx] <= din;
    end

    for (genvar k = 0; k < 4; k++) begin : g_byte
        assign word[8*k +: 8] = (2'(k) > len) ? 8'h00 :
                                (2'(k) == idx) ? din : bytes_q[k];
    end

endmodule

// File: rtl/mem_ctrl.sv
// Single-port byte-wide RAM arbiter: serialises 32-bit instruction fetches and
// 1/2/4-byte data loads/stores into byte accesses. Data has priority over fetch.
//   clk, rst_n            : clock, asynchronous active-low reset
//   pc_mem, fetch_req     : fetch request from IF (taken only when idle)
//   addr_needed           : controller idle
//   inst_available        : one-cycle pulse, inst_in/pc_back valid
//   branch_interception   : abort an in-flight fetch
//   memcnf                : 00 free, 01 data waiting, 10 data access active
//   d_req/d_we/d_len/d_addr/d_wdata : MEM stage request, held until d_done
//   d_done, d_rdata       : completion pulse and zero-extended load data
//   ram_a/ram_wr/ram_dout : registered RAM interface; ram_din valid next cycle
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int RAM_AW = 17
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       pc_mem,
    input  logic              fetch_req,
    output logic              addr_needed,
    output logic              inst_available,
    output logic [31:0]       inst_in,
    output logic [31:0]       pc_back,
    input  logic              branch_interception,
    output logic [1:0]        memcnf,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_len,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_done,
    output logic [31:0]       d_rdata,
    output logic [RAM_AW-1:0] ram_a,
    output logic              ram_wr,
    output logic [7:0]        ram_dout,
    input  logic [7:0]        ram_din
);

    state_t            state, state_nx;
    logic [2:0]        cnt, cnt_nx;
    req_t              req, req_nx;
    logic [RAM_AW-1:0] ram_a_nx, next_a;
    logic              ram_wr_nx, inst_available_nx, d_done_nx;
    logic [7:0]        ram_dout_nx;
    logic [31:0]       inst_in_nx, pc_back_nx, d_rdata_nx, asm_word;
    logic              last, cap;

    // cnt is the byte slot in flight; the access ends on slot len.
    assign last   = (cnt == {1'b0, req.len});
    assign next_a = req.addr[RAM_AW-1:0] + RAM_AW'(cnt) + RAM_AW'(1);
    assign cap    = (state == DREAD) || (state == IFETCH && !branch_interception);

    assign addr_needed = (state == IDLE);

    // d_req is still high in its own d_done cycle, so it is masked there.
    always_comb begin
        if (state == DREAD || state == DWRITE) memcnf = MEMCNF_BUSY;
        else if (d_req && !d_done)             memcnf = MEMCNF_WAIT;
        else                                   memcnf = MEMCNF_FREE;
    end

    byte_assembler u_asm (
        .clk   (clk),
        .rst_n (rst_n),
        .cap   (cap),
        .idx   (cnt[1:0]),
        .len   (req.len),
        .din   (ram_din),
        .word  (asm_word)
    );

    always_comb begin
        state_nx          = state;
        cnt_nx            = cnt;
        req_nx            = req;
        ram_a_nx          = ram_a;
        ram_wr_nx         = 1'b0;
        ram_dout_nx       = ram_dout;
        inst_available_nx = 1'b0;
        d_done_nx         = 1'b0;
        inst_in_nx        = inst_in;
        pc_back_nx        = pc_back;
        d_rdata_nx        = d_rdata;
        unique case (state)
            IDLE: begin
                if (d_req && !d_done) begin
                    req_nx   = '{addr: d_addr, len: d_len, wdata: d_wdata};
                    cnt_nx   = 3'd0;
                    ram_a_nx = d_addr[RAM_AW-1:0];
                    if (d_we) begin
                        state_nx    = DWRITE;
                        ram_wr_nx   = 1'b1;
                        ram_dout_nx = d_wdata[7:0];
                    end else begin
                        state_nx = DREAD;
                    end
                end else if (fetch_req && !branch_interception) begin
                    req_nx   = '{addr: pc_mem, len: DLEN_WORD, wdata: 32'd0};
                    cnt_nx   = 3'd0;
                    ram_a_nx = pc_mem[RAM_AW-1:0];
                    state_nx = IFETCH;
                end
            end
            IFETCH: begin
                if (branch_interception) begin
                    state_nx = IDLE;
                end else if (last) begin
                    state_nx          = IDLE;
                    inst_available_nx = 1'b1;
                    inst_in_nx        = asm_word;
                    pc_back_nx        = req.addr;
                end else begin
                    cnt_nx   = cnt + 3'd1;
                    ram_a_nx = next_a;
                end
            end
            DREAD: begin
                if (last) begin
                    state_nx   = IDLE;
                    d_done_nx  = 1'b1;
                    d_rdata_nx = asm_word;
                end else begin
                    cnt_nx   = cnt + 3'd1;
                    ram_a_nx = next_a;
                end
            end
            DWRITE: begin
                // ram_wr is high for the whole current cycle; the slot in
                // flight is written on the edge that ends it.
                if (last) begin
                    state_nx  = IDLE;
                    d_done_nx = 1'b1;
                end else begin
                    cnt_nx      = cnt + 3'd1;
                    ram_a_nx    = next_a;
                    ram_wr_nx   = 1'b1;
                    ram_dout_nx = get_byte(req.wdata, cnt[1:0] + 2'd1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= 3'd0;
            req            <= '0;
            ram_a          <= '0;
            ram_wr         <= 1'b0;
            ram_dout       <= 8'd0;
            inst_available <= 1'b0;
            d_done         <= 1'b0;
            inst_in        <= 32'd0;
            pc_back        <= 32'd0;
            d_rdata        <= 32'd0;
        end else begin
            state          <= state_nx;
            cnt            <= cnt_nx;
            req            <= req_nx;
            ram_a          <= ram_a_nx;
            ram_wr         <= ram_wr_nx;
            ram_dout       <= ram_dout_nx;
            inst_available <= inst_available_nx;
            d_done         <= d_done_nx;
            inst_in        <= inst_in_nx;
            pc_back        <= pc_back_nx;
            d_rdata        <= d_rdata_nx;
        end
    end

endmodule
